// File: rtl/frame_buf_pkg.sv
// Shared constants for the ping-pong frame buffer: strobe polarities and per-bank occupancy encoding.
package frame_buf_pkg;

   localparam logic ASSERT_L   = 1'b0;
   localparam logic DEASSERT_L = 1'b1;
   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;

   localparam logic BANK_EMPTY = 1'b0;
   localparam logic BANK_FULL  = 1'b1;

endpackage

// File: rtl/frame_buf_pingpong_if.sv
// Writer/reader bus of the ping-pong frame buffer; the master drives strobes and addresses, the slave is the buffer.
interface frame_buf_pingpong_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);

   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  wr_frame_done;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_en;
   logic                  rd_frame_done;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  frame_ready;
   logic                  wr_bank;
   logic                  rd_bank;
   logic                  overrun;

   modport master (
      output wr_addr, wr_data, wr_en, wr_frame_done, rd_addr, rd_en, rd_frame_done,
      input  rd_data, rd_valid, frame_ready, wr_bank, rd_bank, overrun
   );

   modport slave (
      input  wr_addr, wr_data, wr_en, wr_frame_done, rd_addr, rd_en, rd_frame_done,
      output rd_data, rd_valid, frame_ready, wr_bank, rd_bank, overrun
   );

endinterface

// File: rtl/frame_buf_sdp_ram.sv
// Two-bank simple dual-port RAM; bank b occupies words b*MEM_DEPTH .. b*MEM_DEPTH+MEM_DEPTH-1.
module frame_buf_sdp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  rd_bank,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int IDX_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [2*MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_p1;

   // Offset by MEM_DEPTH rather than concatenating so non-power-of-two depths pack densely.
   function automatic logic [IDX_W-1:0] word_idx(input logic bank, input logic [ADDR_WIDTH-1:0] addr);
      return bank ? IDX_W'(MEM_DEPTH) + IDX_W'(addr) : IDX_W'(addr);
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) mem[word_idx(wr_bank, wr_addr)] <= wr_data;
   end

   // p0 -> p1: registered read port, holds its value when no read is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_data_p1 <= '0;
      else if (rd_en) rd_data_p1 <= mem[word_idx(rd_bank, rd_addr)];
   end

   assign rd_data = rd_data_p1;

endmodule

// File: rtl/frame_buf_pingpong.sv
// Ping-pong frame buffer: writer fills one bank while the reader drains the other; banks swap on frame-done strobes.
module frame_buf_pingpong
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   frame_buf_pingpong_if.slave  bus
);

   logic [1:0]            bank_full;
   logic [1:0]            bank_full_nxt;
   logic                  wr_bank_q;
   logic                  rd_bank_q;
   logic                  overrun_q;
   logic                  vld_p1;
   logic                  frame_ready;
   logic                  wr_req;
   logic                  wr_accept;
   logic                  wr_drop;
   logic                  wfd_accept;
   logic                  rd_accept;
   logic                  rfd_accept;
   logic [DATA_WIDTH-1:0] rd_data_p1;

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
      return int'(addr) < MEM_DEPTH;
   endfunction

   assign frame_ready = bank_full[rd_bank_q];
   assign wr_req      = (bus.wr_en == ASSERT_L);
   assign wr_accept   = wr_req && (bank_full[wr_bank_q] == BANK_EMPTY) && addr_ok(bus.wr_addr);
   assign wr_drop     = wr_req && (bank_full[wr_bank_q] == BANK_FULL);
   assign wfd_accept  = (bus.wr_frame_done == ASSERT_L) && (bank_full[wr_bank_q] == BANK_EMPTY);
   assign rd_accept   = (bus.rd_en == ASSERT_L) && frame_ready && addr_ok(bus.rd_addr);
   assign rfd_accept  = (bus.rd_frame_done == ASSERT_L) && frame_ready;

   // An accepted close needs an empty bank and an accepted release a full one, so they never target the same bank.
   always_comb begin
      bank_full_nxt = bank_full;
      if (wfd_accept) bank_full_nxt[wr_bank_q] = BANK_FULL;
      if (rfd_accept) bank_full_nxt[rd_bank_q] = BANK_EMPTY;
   end

   // p0 -> p1: bank state update and read-valid pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_full <= {BANK_EMPTY, BANK_EMPTY};
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         overrun_q <= DEASSERT_H;
         vld_p1    <= DEASSERT_H;
      end else begin
         bank_full <= bank_full_nxt;
         if (wfd_accept) wr_bank_q <= ~wr_bank_q;
         if (rfd_accept) rd_bank_q <= ~rd_bank_q;
         if (wr_drop)    overrun_q <= ASSERT_H;
         vld_p1 <= rd_accept;
      end
   end

   frame_buf_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_accept),
      .wr_bank (wr_bank_q),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_en   (rd_accept),
      .rd_bank (rd_bank_q),
      .rd_addr (bus.rd_addr),
      .rd_data (rd_data_p1)
   );

   assign bus.rd_data     = rd_data_p1;
   assign bus.rd_valid    = vld_p1;
   assign bus.frame_ready = frame_ready;
   assign bus.wr_bank     = wr_bank_q;
   assign bus.rd_bank     = rd_bank_q;
   assign bus.overrun     = overrun_q;

endmodule
